// File: rtl/adder6bit_rr_sched.sv
// adder6bit_rr_sched: round-robin scheduler sharing one 6-bit ripple adder
// among NUM_REQ requesters. The winning operand pair is added and the sum,
// carry-out and requester ID are registered into a valid/ready output stage.
// Optional build macro: ADDER6BIT_SCHED_SAT_EN (saturate sum to 6'h3F on carry-out).

`timescale 1ns/1ps

// 6-bit ripple-carry adder with carry-in tied to 0.
module adder6bit (
    input  logic [5:0] a_i,
    input  logic [5:0] b_i,
    output logic [5:0] sum_o,
    output logic       cout_o
);

    // Ripple the carry through six full-adder cells.
    always_comb begin
        logic carry;
        // NOTE: combinational blocks use blocking '=' and give every output a
        // default first, so no path leaves a variable unassigned (no latch).
        sum_o = '0;
        carry = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

module adder6bit_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [6*NUM_REQ-1:0] req_in1,
    input  logic [6*NUM_REQ-1:0] req_in2,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 out_valid,
    output logic [ID_W-1:0]      out_id,
    output logic [5:0]           out_sum,
    output logic                 out_cout,
    input  logic                 out_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        STALL = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic [5:0]          out_sum_q, out_sum_d;
    logic                out_cout_q, out_cout_d;

    logic                accept_en;
    logic                found;
    logic [ID_W-1:0]     win;
    logic [NUM_REQ-1:0]  grant;
    logic                ack_any;
    logic [5:0]          sel_a, sel_b;
    logic [5:0]          add_sum;
    logic                add_cout;
    logic [5:0]          res_sum;

    // The output register can take a new result when empty or being drained.
    assign accept_en = !out_valid_q || out_ready;

    // Round-robin search: first valid request at or after rr_ptr, wrapping.
    always_comb begin
        logic [ID_W:0]   pos;
        logic [ID_W-1:0] cand;
        found = 1'b0;
        win   = '0;
        grant = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(NUM_REQ)) begin
                pos = pos - (ID_W+1)'(NUM_REQ);
            end
            cand = pos[ID_W-1:0];
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                win         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    // Ack is suppressed while the output stage is stalled or reset is held.
    assign req_ack = (found && accept_en && rst_n) ? grant : '0;
    assign ack_any = |req_ack;

    // One-hot AND-OR mux picks the winner's operands for the shared adder.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = sel_a | req_in1[6*i +: 6];
                sel_b = sel_b | req_in2[6*i +: 6];
            end
        end
    end

    adder6bit u_adder (
        .a_i    (sel_a),
        .b_i    (sel_b),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

`ifdef ADDER6BIT_SCHED_SAT_EN
    // Clamp to the largest 6-bit value whenever the add overflows.
    assign res_sum = add_cout ? 6'h3F : add_sum;
`else
    // Raw wrapped sum.
    assign res_sum = add_sum;
`endif

    // Output stage and pointer next-state: load on ack, drain on handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        rr_ptr_d    = rr_ptr_q;
        if (ack_any) begin
            out_valid_d = 1'b1;
            out_id_d    = win;
            out_sum_d   = res_sum;
            out_cout_d  = add_cout;
            rr_ptr_d    = (win == ID_W'(NUM_REQ-1)) ? '0 : win + ID_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // FSM next-state: tracks whether the result stage is empty, moving or held.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ack_any) state_d = BUSY;
            end
            BUSY: begin
                if (!out_ready)   state_d = STALL;
                else if (ack_any) state_d = BUSY;
                else              state_d = IDLE;
            end
            STALL: begin
                if (out_ready) state_d = ack_any ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' and every register is
        // cleared by the asynchronous reset so the block always starts in IDLE.
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder6bit_rr_sched.sv
// Self-checking bench for adder6bit_rr_sched: directed scenarios plus a
// randomized phase, all checked against a behavioural model of the scheduler.

`timescale 1ns/1ps

module tb_adder6bit_rr_sched;

    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [6*N-1:0] req_in1;
    logic [6*N-1:0] req_in2;
    logic [N-1:0]   req_ack;
    logic           out_valid;
    logic [IW-1:0]  out_id;
    logic [5:0]     out_sum;
    logic           out_cout;
    logic           out_ready;
    logic           busy;

    always #5 clk = ~clk;

    adder6bit_rr_sched #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_ack   (req_ack),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Requester-side stimulus state.
    logic [5:0]   op_a [N];
    logic [5:0]   op_b [N];
    logic [N-1:0] pend;

    // Reference model state.
    int   m_ptr;
    logic m_valid;
    int   m_id;
    int   m_sum;
    logic m_cout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_in1[6*i +: 6] = op_a[i];
            req_in2[6*i +: 6] = op_b[i];
        end
        req_valid = pend;
    endtask

    function automatic int ref_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_id    = 0;
        m_sum   = 0;
        m_cout  = 1'b0;
    endtask

    task automatic set_req(input int i, input int a, input int b);
        pend[i] = 1'b1;
        op_a[i] = 6'(a);
        op_b[i] = 6'(b);
    endtask

    // One clock: apply inputs, check combinational and registered outputs
    // mid-cycle, then advance the model across the rising edge.
    task automatic cycle(input string tag);
        int           w;
        int           s;
        logic [N-1:0] exp_ack;
        drive();
        @(negedge clk);
        w       = ref_winner(pend, m_ptr);
        exp_ack = '0;
        if ((!m_valid || out_ready) && w >= 0) exp_ack[w] = 1'b1;
        check({tag, "/ack"},   32'(req_ack),   32'(exp_ack));
        check({tag, "/valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, "/busy"},  32'(busy),      32'(m_valid));
        check({tag, "/id"},    32'(out_id),    32'(m_id));
        check({tag, "/sum"},   32'(out_sum),   32'(m_sum));
        check({tag, "/cout"},  32'(out_cout),  32'(m_cout));
        @(posedge clk);
        if (exp_ack != '0) begin
            s      = int'(op_a[w]) + int'(op_b[w]);
            m_cout = (s > 63);
            m_sum  = s % 64;
`ifdef ADDER6BIT_SCHED_SAT_EN
            if (m_cout) m_sum = 63;
`endif
            m_id    = w;
            m_valid = 1'b1;
            m_ptr   = (w + 1) % N;
            pend[w] = 1'b0;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        pend      = '1;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        drive();
        model_reset();

        // Reset state, with every request raised to confirm acks are held off.
        #12;
        check("rst/ack",   32'(req_ack),   32'd0);
        check("rst/valid", 32'(out_valid), 32'd0);
        check("rst/id",    32'(out_id),    32'd0);
        check("rst/sum",   32'(out_sum),   32'd0);
        check("rst/cout",  32'(out_cout),  32'd0);
        check("rst/busy",  32'(busy),      32'd0);
        pend = '0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First transaction: 5 + 9 on requester 0.
        set_req(0, 5, 9);
        cycle("first");
        check("first/sum14", 32'(out_sum), 32'd14);
        cycle("first_drain");

        // All requesters valid continuously: 0,1,2,3,0,... with no bubbles.
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) set_req(i, $urandom_range(0, 63), $urandom_range(0, 63));
            end
            cycle("stream");
        end
        pend = '0;
        cycle("stream_drain");
        cycle("stream_idle");

        // Wrap-around: put pointer at 2 via requester 1, then 1 and 3 compete.
        set_req(1, 3, 4);
        cycle("wrap_setup");
        set_req(1, 10, 20);
        set_req(3, 30, 40);
        cycle("wrap_a");
        check("wrap/first_id3", 32'(out_id), 32'd3);
        cycle("wrap_b");
        check("wrap/then_id1", 32'(out_id), 32'd1);
        cycle("wrap_drain");

        // Carry-out boundaries on requester 2.
        set_req(2, 63, 1);
        cycle("ovf1");
        check("ovf1/cout", 32'(out_cout), 32'd1);
`ifdef ADDER6BIT_SCHED_SAT_EN
        check("ovf1/sum_sat", 32'(out_sum), 32'd63);
`else
        check("ovf1/sum_wrap", 32'(out_sum), 32'd0);
`endif
        set_req(2, 63, 63);
        cycle("ovf2");
        check("ovf2/cout", 32'(out_cout), 32'd1);
`ifdef ADDER6BIT_SCHED_SAT_EN
        check("ovf2/sum_sat", 32'(out_sum), 32'd63);
`else
        check("ovf2/sum_wrap", 32'(out_sum), 32'd62);
`endif

        // Stall: result pending, consumer not ready, requester 1 waiting.
        out_ready = 1'b0;
        set_req(1, 7, 8);
        for (int c = 0; c < 3; c++) cycle("stall");
        out_ready = 1'b1;
        cycle("stall_release");
        check("stall/new_id", 32'(out_id),  32'd1);
        check("stall/new_sum", 32'(out_sum), 32'd15);
        cycle("stall_drain");

        // Randomized traffic with random back-pressure and withdrawals.
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 2) == 0) set_req(i, $urandom_range(0, 63), $urandom_range(0, 63));
                end else if ($urandom_range(0, 9) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            cycle("rand");
        end

        // Asynchronous reset mid-stream with a result held.
        out_ready = 1'b0;
        pend      = '0;
        set_req(0, 1, 2);
        cycle("pre_rst_load");
        check("pre_rst/valid", 32'(out_valid), 32'd1);
        set_req(3, 5, 5);
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst/valid", 32'(out_valid), 32'd0);
        check("async_rst/ack",   32'(req_ack),   32'd0);
        check("async_rst/busy",  32'(busy),      32'd0);
        model_reset();
        pend = '0;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        set_req(2, 11, 12);
        set_req(3, 13, 14);
        cycle("post_rst");
        check("post_rst/id2", 32'(out_id), 32'd2);
        cycle("post_rst_b");
        check("post_rst/id3", 32'(out_id), 32'd3);
        cycle("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
